// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the CPU data-port responder: word width, the I/O register
// addresses at the top of the map, console status bit positions and the address decoder.
package data_bus_responder_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [WORD_WIDTH-1:0] CONSOLE_TX     = 16'hFF00;
  localparam logic [WORD_WIDTH-1:0] CONSOLE_STAT   = 16'hFF01;
  localparam logic [WORD_WIDTH-1:0] CONSOLE_CYCLES = 16'hFF02;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_TX,
    REGION_STAT,
    REGION_CYCLES,
    REGION_NONE
  } region_e;

  // The RAM occupies every address whose bits above ram_aw are all zero.
  function automatic region_e decode_addr(input logic [WORD_WIDTH-1:0] addr,
                                          input int                    ram_aw);
    region_e r;
    if ((addr >> ram_aw) == '0)        r = REGION_RAM;
    else if (addr == CONSOLE_TX)       r = REGION_TX;
    else if (addr == CONSOLE_STAT)     r = REGION_STAT;
    else if (addr == CONSOLE_CYCLES)   r = REGION_CYCLES;
    else                               r = REGION_NONE;
    return r;
  endfunction

endpackage

// File: rtl/data_bus_responder_tx_fifo.sv
// Byte-wide console transmit FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module data_bus_responder_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_req_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     push_rejected_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A pop frees the slot this same edge, so a full FIFO can still take a push.
  assign do_pop          = pop_req_i & ~empty_o;
  assign do_push         = push_i & (~full_o | do_pop);
  assign push_rejected_o = push_i & ~do_push;

  assign head_o   = empty_o ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-memory responder: word RAM in the low range, console TX FIFO, its
// status and a free-running cycle counter at the top. Reads are combinational.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] data_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  write_en,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  region_e                     region;
  logic [WORD_WIDTH-1:0]       ram_q [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0]   ram_idx;
  logic                        ram_we;
  logic                        tx_push;
  logic                        stat_wr;
  logic                        cyc_wr;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push_rejected;
  logic [CNT_W-1:0]            fifo_count;
  logic [WORD_WIDTH-1:0]       stat_word;
  logic                        ovf_q, ovf_d;
  logic [WORD_WIDTH-1:0]       cyc_q, cyc_d;

  assign region  = decode_addr(data_addr, RAM_ADDR_WIDTH);
  assign ram_idx = data_addr[RAM_ADDR_WIDTH-1:0];
  assign ram_we  = write_en & (region == REGION_RAM);
  assign tx_push = write_en & (region == REGION_TX);
  assign stat_wr = write_en & (region == REGION_STAT);
  assign cyc_wr  = write_en & (region == REGION_CYCLES);

  // Console handshake: a byte transfers on every posedge where tx_valid and
  // tx_ready are both high; tx_valid and tx_data depend only on registered state.
  data_bus_responder_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i          (clk),
    .rst_ni         (rst),
    .push_i         (tx_push),
    .push_data_i    (wr_data[7:0]),
    .pop_req_i      (tx_ready),
    .head_o         (tx_data),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .count_o        (fifo_count),
    .push_rejected_o(push_rejected)
  );

  assign tx_valid = ~fifo_empty;

  always_comb begin
    stat_word                 = '0;
    stat_word[15:8]           = 8'(fifo_count);
    stat_word[STAT_OVF_BIT]   = ovf_q;
    stat_word[STAT_EMPTY_BIT] = fifo_empty;
    stat_word[STAT_FULL_BIT]  = fifo_full;
  end

  always_comb begin
    rd_data = '0;
    case (region)
      REGION_RAM:    rd_data = ram_q[ram_idx];
      REGION_STAT:   rd_data = stat_word;
      REGION_CYCLES: rd_data = cyc_q;
      default:       rd_data = '0;
    endcase
  end

  // A dropped push in the same cycle as a clear leaves overflow set.
  always_comb begin
    ovf_d = ovf_q;
    if (push_rejected)                      ovf_d = 1'b1;
    else if (stat_wr && wr_data[STAT_OVF_BIT]) ovf_d = 1'b0;
  end

  assign cyc_d = cyc_wr ? wr_data : cyc_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cyc_q <= cyc_d;
    end
  end

  // Contents survive reset; only a store pending at a reset edge is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (ram_we) begin
      ram_q[ram_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: an address-map-level model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_data_bus_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_addr;
  logic [15:0] wr_data;
  logic        write_en;
  logic        tx_ready;
  logic [15:0] rd_data;
  logic        tx_valid;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram_m [256];
  bit          ram_known [256];
  logic [7:0]  fifo_m [$];
  bit          ovf_m = 1'b0;
  logic [15:0] cyc_m = 16'h0000;
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  bit m_pop, m_push, m_accept;

  data_bus_responder #(
    .RAM_ADDR_WIDTH(8),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_addr(data_addr),
    .wr_data  (wr_data),
    .write_en (write_en),
    .rd_data  (rd_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    logic [15:0] s;
    s = 16'h0000;
    if (a < 16'h0100) begin
      s = ram_m[a[7:0]];
    end else if (a == 16'hFF01) begin
      s[15:8] = 8'(fifo_m.size());
      s[2]    = ovf_m;
      s[1]    = (fifo_m.size() == 0);
      s[0]    = (fifo_m.size() == DEPTH);
    end else if (a == 16'hFF02) begin
      s = cyc_m;
    end
    return s;
  endfunction

  // Model state advances on each clock edge from the inputs held over that cycle.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      fifo_m.delete();
      ovf_m = 1'b0;
      cyc_m = 16'h0000;
    end else begin
      m_pop    = (fifo_m.size() != 0) && tx_ready;
      m_push   = write_en && (data_addr == 16'hFF00);
      m_accept = m_push && ((fifo_m.size() < DEPTH) || m_pop);
      if (m_pop) void'(fifo_m.pop_front());
      if (m_accept) fifo_m.push_back(wr_data[7:0]);
      if (m_push && !m_accept) ovf_m = 1'b1;
      else if (write_en && data_addr == 16'hFF01 && wr_data[2]) ovf_m = 1'b0;
      cyc_m = (write_en && data_addr == 16'hFF02) ? wr_data : cyc_m + 16'd1;
      if (write_en && data_addr < 16'h0100) begin
        ram_m[data_addr[7:0]]     = wr_data;
        ram_known[data_addr[7:0]] = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (data_addr >= 16'h0100 || ram_known[data_addr[7:0]])
      chk("rd_data", rd_data, model_rd(data_addr));
    chk("tx_valid", {15'b0, tx_valid}, {15'b0, fifo_m.size() != 0});
    if (fifo_m.size() != 0) chk("tx_data", {8'b0, tx_data}, {8'b0, fifo_m[0]});
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we,
                       input logic rdy);
    @(negedge clk);
    data_addr = a;
    wr_data   = d;
    write_en  = we;
    tx_ready  = rdy;
  endtask

  task automatic peek(input string name, input logic [15:0] exp);
    #3;
    chk(name, rd_data, exp);
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) drive(16'hFF00, {8'h00, first + 8'(i)}, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    got_q.delete();
    n = 0;
    while (n < 16) begin
      drive(16'hFF01, 16'h0000, 1'b0, 1'b1);
      #3;
      if (!tx_valid) break;
      got_q.push_back(tx_data);
      n++;
    end
    chk({name, "_len"}, 16'(got_q.size()), 16'(exp_q.size()));
    while (exp_q.size() != 0 && got_q.size() != 0)
      chk({name, "_byte"}, {8'b0, got_q.pop_front()}, {8'b0, exp_q.pop_front()});
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    data_addr = 16'h0300;
    wr_data   = 16'h0000;
    write_en  = 1'b0;
    tx_ready  = 1'b0;
    #1 rst = 1'b0;

    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("reset_stat", 16'h0002);
    chk("reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("reset_tx_data", {8'b0, tx_data}, 16'h0000);
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
    peek("reset_cycles", 16'h0000);
    drive(16'h0300, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;

    drive(16'h0000, 16'h00AA, 1'b1, 1'b0);
    drive(16'h0010, 16'h1234, 1'b1, 1'b0);
    drive(16'h0010, 16'h0000, 1'b0, 1'b0);
    peek("ram_rd", 16'h1234);
    drive(16'h0010, 16'hBEEF, 1'b1, 1'b0);
    peek("ram_rd_old", 16'h1234);
    drive(16'h0010, 16'h0000, 1'b0, 1'b0);
    peek("ram_rd_new", 16'hBEEF);
    drive(16'h0300, 16'h9999, 1'b1, 1'b0);
    peek("unmapped_rd", 16'h0000);
    drive(16'hFF03, 16'h7777, 1'b1, 1'b0);
    peek("unmapped_rd2", 16'h0000);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    peek("ram_no_alias", 16'h00AA);

    push_bytes(8'h41, 4);
    drive(16'hFF00, 16'h0045, 1'b1, 1'b0);
    peek("tx_reg_rd", 16'h0000);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("stat_full_ovf", 16'h0405);
    chk("head_first", {8'b0, tx_data}, 16'h0041);
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    drain("drain1");
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("stat_drained", 16'h0006);

    drive(16'hFF01, 16'h0003, 1'b1, 1'b0);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("ovf_kept", 16'h0006);
    drive(16'hFF01, 16'h0004, 1'b1, 1'b0);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("ovf_cleared", 16'h0002);

    push_bytes(8'h50, 4);
    drive(16'hFF00, 16'h0055, 1'b1, 1'b1);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("stat_full_pop", 16'h0401);
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h55};
    drain("drain2");

    drive(16'hFF02, 16'hFFFE, 1'b1, 1'b0);
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
    peek("cyc_loaded", 16'hFFFE);
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
    peek("cyc_ffff", 16'hFFFF);
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
    peek("cyc_wrap", 16'h0000);
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
    peek("cyc_one", 16'h0001);
    drive(16'hFF02, 16'h0100, 1'b1, 1'b0);
    drive(16'hFF02, 16'h0100, 1'b1, 1'b0);
    peek("cyc_held_load", 16'h0100);
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
    peek("cyc_held_load2", 16'h0100);

    drive(16'h0020, 16'h1111, 1'b1, 1'b0);
    push_bytes(8'h60, 4);
    drive(16'hFF00, 16'h0064, 1'b1, 1'b0);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("stat_ovf2", 16'h0405);
    drive(16'hFF01, 16'h0004, 1'b1, 1'b0);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("ovf_cleared2", 16'h0401);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b1);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b1);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("occupancy_two", 16'h0200);
    chk("head_after_pops", {8'b0, tx_data}, 16'h0062);

    drive(16'h0020, 16'h7777, 1'b1, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("rst_tx_data", {8'b0, tx_data}, 16'h0000);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("stat_in_reset", 16'h0002);
    drive(16'h0300, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
    peek("stat_after_reset", 16'h0002);
    drive(16'h0020, 16'h0000, 1'b0, 1'b0);
    peek("store_dropped", 16'h1111);
    drive(16'h0300, 16'h0000, 1'b0, 1'b0);
    drive(16'h0300, 16'h0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
